// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time; grant lands 1 cycle after the req sample in IDLE.
// A holder keeps the grant until done, its own req drops, or the hold limit forces release (timeout pulse).
module rr_arbiter_8 #(
   parameter int unsigned HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic       en,
   output logic       timeout
);

   localparam int unsigned HW = $clog2(HOLD_MAX + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state_q;
   logic [2:0]    ptr_q;
   logic [2:0]    cur_q;
   logic [HW-1:0] hold_q;
   logic [7:0]    gnt_q;
   logic          en_q;
   logic          timeout_q;

   logic [2:0]    pick_d;
   logic          pick_vld_d;
   logic [2:0]    idx_d;
   logic          hold_lim_d;
   logic          rel_d;

   // First requester after the last granted index, wrapping modulo 8.
   always_comb begin
      pick_d     = ptr_q;
      pick_vld_d = 1'b0;
      idx_d      = ptr_q;
      for (int k = 1; k <= 8; k++) begin
         idx_d = ptr_q + k[2:0];
         if (!pick_vld_d && req[idx_d]) begin
            pick_d     = idx_d;
            pick_vld_d = 1'b1;
         end
      end
   end

   assign hold_lim_d = (hold_q == HW'(HOLD_MAX - 1));
   assign rel_d      = done | ~req[cur_q] | hold_lim_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         en_q      <= 1'b0;
         timeout_q <= 1'b0;
         hold_q    <= '0;
         ptr_q     <= 3'd7;
         cur_q     <= 3'd0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pick_vld_d) begin
                  gnt_q   <= 8'b1 << pick_d;
                  en_q    <= 1'b1;
                  cur_q   <= pick_d;
                  hold_q  <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               if (rel_d) begin
                  gnt_q     <= '0;
                  en_q      <= 1'b0;
                  ptr_q     <= cur_q;
                  // Only a pure hold-limit release is a timeout; done or a dropped req wins.
                  timeout_q <= hold_lim_d & ~done & req[cur_q];
                  state_q   <= IDLE;
               end else begin
                  hold_q <= hold_q + HW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt     = gnt_q;
   assign en      = en_q;
   assign timeout = timeout_q;

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 15, giving the maximum number of cycles a grant is held without done; legal range is 2..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: level request lines, where bit i is the request from source i.
REQ-005 The block SHALL have port done, input, 1 bit: the holder releases the current grant.
REQ-006 The block SHALL have port gnt, output, 8 bits: a registered one-hot grant, or all zeros; it feeds the downstream 8-to-3 encoder input.
REQ-007 The block SHALL have port en, output, 1 bit: registered grant-valid, driving the downstream encoder En.
REQ-008 The block SHALL have port timeout, output, 1 bit: a registered one-cycle pulse when a grant is force-released.

Function
REQ-009 The block SHALL use an FSM with states IDLE and GRANT, plus a 3-bit round-robin pointer ptr holding the last granted index.
REQ-010 In IDLE with req != 0, the block SHALL select the first set req bit searching ptr+1, ptr+2, ... modulo 8, and load gnt with that one-hot, en=1, state=GRANT at the next edge.
REQ-011 In IDLE with req == 0, the block SHALL keep gnt=0, en=0 and leave ptr unchanged.
REQ-012 Grant latency SHALL be exactly 1 cycle from the req-sampling edge in IDLE.
REQ-013 gnt SHALL only ever be zero or one-hot, and en SHALL equal (gnt != 0) in every cycle.
REQ-014 The block SHALL keep a hold counter, cleared on entry to GRANT and incremented by 1 each cycle in GRANT, with width ceil(log2(HOLD_MAX+1)) and no wrap.
REQ-015 In GRANT, the block SHALL release when any one of the following holds:
- done=1;
- the req bit of the granted index is 0;
- hold counter == HOLD_MAX-1.
REQ-016 On release, at the next edge the block SHALL set gnt=0, en=0, state=IDLE and ptr to the released index.
REQ-017 Each release SHALL be followed by at least one IDLE cycle, so back-to-back grants are separated by exactly 1 cycle with en=0.
REQ-018 timeout SHALL be 1 for exactly the cycle after a release caused only by the hold limit.
REQ-019 If done=1 coincides with hold counter == HOLD_MAX-1, the release SHALL count as normal and timeout SHALL stay 0.
REQ-020 If the granted req drops together with done, the result SHALL be a single normal release with timeout 0.
REQ-021 Changes on non-granted req bits during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 Pointer wrap: when ptr=7, the search SHALL start at index 0; when ptr=i and only req[i] is set, source i SHALL be re-granted.

Reset
REQ-024 While rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=8'h00, en=0, timeout=0, hold counter=0 and ptr=7, so the first search starts at index 0.
REQ-025 Reset asserted mid-GRANT SHALL drop gnt and en to 0 at that same edge with no timeout pulse, and no arbitration SHALL occur while rst=1.
REQ-026 After rst deasserts, the first grant SHALL appear 1 cycle after the first edge that samples req != 0.

Verification
REQ-027 Reset then req=8'hFF held, done pulsed 1 cycle at each grant's second cycle -> gnt sequence 01,02,04,...,80,01, with en=0 for 1 cycle between each grant.
REQ-028 ptr=2 after releasing source 2, req=8'b0000_0101 -> gnt=8'h01 (wrap past 7 to 0; source 2 is skipped because the search starts at 3).
REQ-029 HOLD_MAX=4, req=8'h10 held, done=0 -> gnt=8'h10 for exactly 4 cycles, then gnt=0, en=0, timeout=1 for 1 cycle, then gnt=8'h10 re-granted.
REQ-030 Granted source 3 drops req[3] in its second GRANT cycle while req[5]=1 -> next cycle gnt=0 and timeout=0, the following cycle gnt=8'h20.
REQ-031 rst=1 asserted in the third cycle of GRANT with gnt=8'h40 -> gnt=8'h00, en=0 at that edge; after release with req=8'h41, gnt=8'h01.
REQ-032 A random req/done stress run of 10k cycles SHALL show gnt always 0 or one-hot, en==|gnt, a granted source never starved beyond 7 other grants, and timeout never asserted when done coincides with the limit.
